clock_time_setter: RTL

//  Front end for the HH:MM:SS clock display: turns the four push-buttons into a

---
 rtl/clock_time_setter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clock_time_setter.sv
// Time-set front end for the HH:MM:SS display: debounces the four keys, runs the
// field edit FSM in BCD, drives the clock load interface and the digit blink mask.
//   state    | meaning
//   S_IDLE   | clock running, waiting for advance
//   S_HRS    | editing hours (HEX5:4 blink)
//   S_MIN    | editing minutes (HEX3:2 blink)
//   S_SEC    | editing seconds (HEX1:0 blink)
//   S_COMMIT | one-cycle set_load of the edited time
module clock_time_setter #(
  parameter logic [19:0] DEBOUNCE_TICKS = 20'd600_000,
  parameter logic [24:0] BLINK_TICKS    = 25'd15_000_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        set_load,
  output logic        set_active,
  output logic [5:0]  blank_mask
);

  typedef enum logic [2:0] {S_IDLE, S_HRS, S_MIN, S_SEC, S_COMMIT} state_t;

  state_t      state;
  logic [3:0]  key_meta, key_sync, key_deb, press;
  logic [19:0] deb_cnt [4];
  logic [23:0] edit;
  logic [24:0] blink_cnt;
  logic        phase;
  logic        adv, inc, dec, cancel, in_set, restart;
  logic [7:0]  fld, fld_max, fld_new;
  logic [5:0]  fld_bits;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v >= vmax)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
    if (v == 8'h00)          return vmax;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta <= 4'hF;
      key_sync <= 4'hF;
      key_deb  <= 4'hF;
      press    <= 4'h0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (key_sync[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEBOUNCE_TICKS - 20'd1) begin
          deb_cnt[i] <= '0;
          key_deb[i] <= key_sync[i];
          press[i]   <= ~key_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  // Only the highest-priority simultaneous press acts.
  assign cancel = press[3];
  assign adv    = press[0] & ~press[3];
  assign inc    = press[1] & ~press[3] & ~press[0];
  assign dec    = press[2] & ~press[3] & ~press[0] & ~press[1];

  assign in_set  = (state == S_HRS) || (state == S_MIN) || (state == S_SEC);
  assign restart = ((state == S_IDLE) && adv) || (state == S_COMMIT) ||
                   (in_set && (cancel || adv || inc || dec));

  always_comb begin
    fld      = edit[7:0];
    fld_max  = 8'h59;
    fld_bits = 6'b000011;
    case (state)
      S_HRS: begin fld = edit[23:16]; fld_max = 8'h23; fld_bits = 6'b110000; end
      S_MIN: begin fld = edit[15:8];  fld_bits = 6'b001100; end
      default: ;
    endcase
    fld_new = inc ? bcd_inc(fld, fld_max) : bcd_dec(fld, fld_max);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      edit      <= 24'h000000;
      set_load  <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      set_load <= 1'b0;
      // Any visible change restarts the blink so the new value shows at once.
      if (restart) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BLINK_TICKS - 25'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 25'd1;
      end
      case (state)
        S_IDLE: if (adv) begin
          edit  <= cur_time;
          state <= S_HRS;
        end
        S_HRS, S_MIN, S_SEC: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (adv) begin
            if (state == S_HRS)      state <= S_MIN;
            else if (state == S_MIN) state <= S_SEC;
            else begin
              state    <= S_COMMIT;
              set_load <= 1'b1;
            end
          end else if (inc || dec) begin
            if (state == S_HRS)      edit[23:16] <= fld_new;
            else if (state == S_MIN) edit[15:8]  <= fld_new;
            else                     edit[7:0]   <= fld_new;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign set_time   = edit;
  assign set_active = (state != S_IDLE);
  assign blank_mask = (in_set && phase) ? fld_bits : 6'b000000;

endmodule
